regs_wb_ctrl: RTL and testbench

Write-back controller for the three-read/one-write register file in the ID stage. It shares the single write port between up to three producers (ALU, load/store unit, mul/div unit) with one grant per cycle. It also keeps a busy scoreboard of destination registers with outstanding writes, so decode can stall on RAW and WAW hazards. All regfile write-port signals come from registers inside this block.

---
 rtl/regs_wb_ctrl_pkg.sv | 29 ++
 rtl/regs_wb_ctrl_if.sv | 40 ++++
 rtl/regs_wb_ctrl_arbiter.sv | 60 ++++++
 rtl/regs_wb_ctrl.sv | 103 ++++++++++
 tb/tb_regs_wb_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regs_wb_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regs_wb_ctrl_pkg
// Shared constants for the ID-stage write-back controller: bus widths,
// requester indices and a small wrap-around index helper used by the arbiter.
// -----------------------------------------------------------------------------
package regs_wb_ctrl_pkg;

    localparam int NREQ  = 3;          // write-back requesters
    localparam int AW    = 5;          // register address width
    localparam int DW    = 32;         // data width
    localparam int NREG  = 1 << AW;    // architectural registers
    localparam int PTR_W = $clog2(NREQ);

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_MDU = 2;

    // Next requester index, wrapping NREQ-1 back to 0.
    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        logic [PTR_W-1:0] res;
        if (idx == PTR_W'(NREQ - 1)) begin
            res = '0;
        end else begin
            res = idx + PTR_W'(1'b1);
        end
        return res;
    endfunction

endpackage

// File: rtl/regs_wb_ctrl_if.sv
// -----------------------------------------------------------------------------
// regs_wb_ctrl_if
// Bundles the requester write-back bus, the decode issue/hazard signals and
// the regfile write port seen by regs_wb_ctrl.
//   slave  : the controller (drives req_ready, issue_ready, rbusy*, we/waddr/wdata)
//   master : requesters + decode + regfile side
// -----------------------------------------------------------------------------
interface regs_wb_ctrl_if;
    import regs_wb_ctrl_pkg::*;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    req_ready;
    logic               issue_valid;
    logic [AW-1:0]      issue_addr;
    logic               issue_ready;
    logic [AW-1:0]      raddr1;
    logic [AW-1:0]      raddr2;
    logic [AW-1:0]      raddr3;
    logic               rbusy1;
    logic               rbusy2;
    logic               rbusy3;
    logic               we;
    logic [AW-1:0]      waddr;
    logic [DW-1:0]      wdata;

    modport slave (
        input  req_valid, req_addr, req_data, issue_valid, issue_addr,
               raddr1, raddr2, raddr3,
        output req_ready, issue_ready, rbusy1, rbusy2, rbusy3, we, waddr, wdata
    );

    modport master (
        output req_valid, req_addr, req_data, issue_valid, issue_addr,
               raddr1, raddr2, raddr3,
        input  req_ready, issue_ready, rbusy1, rbusy2, rbusy3, we, waddr, wdata
    );

endinterface

// File: rtl/regs_wb_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
// One-hot grant over NREQ write-back requesters.
// Macro WB_ARB_RR_EN: defined -> round-robin with a pointer register that moves
// one past the last grant; undefined -> fixed priority (lowest index wins),
// no state and no clock/reset ports.
// Ports:
//   clk, rst  (WB_ARB_RR_EN only) clock, synchronous active-high reset
//   valid_i   requester valid bits
//   grant_o   one-hot grant, subset of valid_i, zero when nothing is valid
// -----------------------------------------------------------------------------
module wb_rr_arbiter
    import regs_wb_ctrl_pkg::*;
(
`ifdef WB_ARB_RR_EN
    input  logic            clk,
    input  logic            rst,
`endif
    input  logic [NREQ-1:0] valid_i,
    output logic [NREQ-1:0] grant_o
);

`ifdef WB_ARB_RR_EN
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [PTR_W-1:0] idx_s;
    logic             found_s;

    // Search starting at the pointer with wrap; first valid requester wins.
    always_comb begin
        grant_o = '0;
        ptr_d   = ptr_q;
        found_s = 1'b0;
        idx_s   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found_s && valid_i[idx_s]) begin
                found_s        = 1'b1;
                grant_o[idx_s] = 1'b1;
                ptr_d          = next_idx(idx_s);
                idx_s          = next_idx(idx_s);
            end else begin
                idx_s = next_idx(idx_s);
            end
        end
    end

    // Pointer register; holds its value in cycles without a grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Isolate the lowest set valid bit (two's-complement trick).
    assign grant_o = valid_i & (~valid_i + NREQ'(1'b1));
`endif

endmodule

// File: rtl/regs_wb_ctrl.sv
// -----------------------------------------------------------------------------
// regs_wb_ctrl
// Write-back controller for the 3R/1W ID-stage register file. Arbitrates the
// single write port among ALU/LSU/MDU, registers the write port, and keeps a
// busy scoreboard for RAW (rbusy*) and WAW (issue_ready) stalls.
// Optional macro WB_ARB_RR_EN selects round-robin arbitration (see arbiter).
// Ports:
//   clk  clock, all state on posedge
//   rst  synchronous active-high reset
//   bus  regs_wb_ctrl_if.slave: req_valid/addr/data/ready, issue_valid/addr/
//        ready, raddr1..3, rbusy1..3, we, waddr, wdata
// -----------------------------------------------------------------------------
module regs_wb_ctrl
    import regs_wb_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    regs_wb_ctrl_if.slave bus
);

    logic [NREQ-1:0] grant_s;
    logic            accept_s;
    logic [AW-1:0]   sel_addr_s;
    logic [DW-1:0]   sel_data_s;
    logic            issue_ready_s;
    logic            issue_fire_s;
    logic            we_q;
    logic [AW-1:0]   waddr_q;
    logic [DW-1:0]   wdata_q;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // An operand is busy unless this cycle's write is forwarding it.
    function automatic logic rd_busy(input logic [NREG-1:0] busy,
                                     input logic [AW-1:0]   raddr,
                                     input logic            we,
                                     input logic [AW-1:0]   waddr);
        return busy[raddr] & ~(we & (waddr == raddr));
    endfunction

    wb_rr_arbiter u_arb (
`ifdef WB_ARB_RR_EN
        .clk     (clk),
        .rst     (rst),
`endif
        .valid_i (bus.req_valid),
        .grant_o (grant_s)
    );

    // Grant is already qualified by valid, so any grant bit is an accept.
    assign accept_s = |grant_s;

    // AND-OR mux of the granted requester's slice.
    always_comb begin
        sel_addr_s = '0;
        sel_data_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            sel_addr_s = sel_addr_s | ({AW{grant_s[i]}} & bus.req_addr[i*AW +: AW]);
            sel_data_s = sel_data_s | ({DW{grant_s[i]}} & bus.req_data[i*DW +: DW]);
        end
    end

    assign issue_ready_s = (bus.issue_addr == {AW{1'b0}}) | ~busy_q[bus.issue_addr];
    assign issue_fire_s  = bus.issue_valid & issue_ready_s & (bus.issue_addr != {AW{1'b0}});

    // Scoreboard next state: clear on commit first, then set, so a same-cycle set wins.
    always_comb begin
        busy_d                 = busy_q;
        busy_d[waddr_q]        = busy_q[waddr_q] & ~we_q;
        busy_d[bus.issue_addr] = busy_d[bus.issue_addr] | issue_fire_s;
        busy_d[0]              = 1'b0;
    end

    // Regfile write port and scoreboard registers; r0 writes never assert we.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= '0;
        end else begin
            we_q   <= accept_s & (sel_addr_s != {AW{1'b0}});
            busy_q <= busy_d;
            if (accept_s) begin
                waddr_q <= sel_addr_s;
                wdata_q <= sel_data_s;
            end else begin
                waddr_q <= waddr_q;
                wdata_q <= wdata_q;
            end
        end
    end

    assign bus.req_ready   = grant_s;
    assign bus.issue_ready = issue_ready_s;
    assign bus.rbusy1      = rd_busy(busy_q, bus.raddr1, we_q, waddr_q);
    assign bus.rbusy2      = rd_busy(busy_q, bus.raddr2, we_q, waddr_q);
    assign bus.rbusy3      = rd_busy(busy_q, bus.raddr3, we_q, waddr_q);
    assign bus.we          = we_q;
    assign bus.waddr       = waddr_q;
    assign bus.wdata       = wdata_q;

endmodule

// File: tb/tb_regs_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regs_wb_ctrl
// Self-checking bench for regs_wb_ctrl. Inputs change on negedge, outputs are
// checked #1 later (combinational) or at the following negedge (registered).
// A behavioural model (busy array, expected write port, arbitration pointer)
// advances at every posedge. Honors WB_ARB_RR_EN like the design.
// -----------------------------------------------------------------------------
module tb_regs_wb_ctrl;
    import regs_wb_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;

    regs_wb_ctrl_if bus();

    regs_wb_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit            m_busy [NREG];
    bit            m_we;
    logic [AW-1:0] m_waddr;
    logic [DW-1:0] m_wdata;
    int            m_ptr;

    function automatic int exp_grant(input logic [NREQ-1:0] v);
`ifdef WB_ARB_RR_EN
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
`else
        for (int k = 0; k < NREQ; k++) begin
            if (v[k]) return k;
        end
`endif
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] exp_ready(input logic [NREQ-1:0] v);
        int g;
        g = exp_grant(v);
        if (g < 0) return '0;
        return NREQ'(1) << g;
    endfunction

    function automatic bit exp_issue_ready(input logic [AW-1:0] a);
        return (a == 0) || !m_busy[a];
    endfunction

    function automatic bit exp_rbusy(input logic [AW-1:0] ra);
        return m_busy[ra] && !(m_we && m_waddr == ra);
    endfunction

    task automatic model_edge();
        int g;
        bit ir;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_ptr = 0;
            return;
        end
        g  = exp_grant(bus.req_valid);
        ir = exp_issue_ready(bus.issue_addr);
        if (m_we) m_busy[m_waddr] = 1'b0;
        if (bus.issue_valid && ir && bus.issue_addr != 0) m_busy[bus.issue_addr] = 1'b1;
        if (g >= 0) begin
            m_waddr = bus.req_addr[g*AW +: AW];
            m_wdata = bus.req_data[g*DW +: DW];
            m_we    = (m_waddr != 0);
            m_ptr   = (g + 1) % NREQ;
        end else begin
            m_we = 1'b0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0;
        bus.issue_valid = 1'b0; bus.issue_addr = '0;
        bus.raddr1 = '0; bus.raddr2 = '0; bus.raddr3 = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 3'b111; bus.issue_valid = 1'b1; bus.issue_addr = 5'd3;
        cycle(); cycle();
        rst = 1'b0;
        idle_inputs();
        bus.req_valid = 3'b110; bus.issue_addr = 5'd13;
        bus.raddr1 = 5'd9; bus.raddr2 = 5'd3; bus.raddr3 = 5'd31;
        #1;
        n_tests++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.we); end
        n_tests++; if (bus.waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d expected 0", bus.waddr); end
        n_tests++; if (bus.wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata: got %0h expected 0", bus.wdata); end
        n_tests++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL reset_issue_ready: got %b expected 1", bus.issue_ready); end
        n_tests++; if ({bus.rbusy1, bus.rbusy2, bus.rbusy3} !== 3'b000) begin n_fail++; $display("FAIL reset_rbusy: got %b expected 000", {bus.rbusy1, bus.rbusy2, bus.rbusy3}); end
        n_tests++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 010", bus.req_ready); end
        idle_inputs();
    endtask

    task automatic test_raw_waw();
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd5;
        cycle();
        bus.issue_valid = 1'b0; bus.raddr1 = 5'd5;
        #1;
        n_tests++; if (bus.rbusy1 !== 1'b1) begin n_fail++; $display("FAIL raw_rbusy_set: got %b expected 1", bus.rbusy1); end
        n_tests++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL waw_issue_stall: got %b expected 0", bus.issue_ready); end
        bus.req_valid = 3'b001; bus.req_addr = {5'd0, 5'd0, 5'd5}; bus.req_data = {32'd0, 32'd0, 32'h1234};
        #1;
        n_tests++; if (bus.req_ready !== 3'b001) begin n_fail++; $display("FAIL alu_grant: got %b expected 001", bus.req_ready); end
        cycle();
        bus.req_valid = 3'b000;
        #1;
        n_tests++; if (bus.we !== 1'b1 || bus.waddr !== 5'd5 || bus.wdata !== 32'h1234) begin n_fail++; $display("FAIL wb_r5: got we=%b waddr=%0d wdata=%0h expected 1/5/1234", bus.we, bus.waddr, bus.wdata); end
        n_tests++; if (bus.rbusy1 !== 1'b0) begin n_fail++; $display("FAIL raw_forward: got %b expected 0", bus.rbusy1); end
        n_tests++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL waw_during_write: got %b expected 0", bus.issue_ready); end
        cycle();
        #1;
        n_tests++; if (bus.we !== 1'b0 || bus.rbusy1 !== 1'b0 || bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL busy_cleared: got we=%b rbusy1=%b issue_ready=%b expected 0/0/1", bus.we, bus.rbusy1, bus.issue_ready); end
        idle_inputs();
    endtask

    task automatic test_arbitration();
        logic [NREQ-1:0] g_tbl [4];
        logic [AW-1:0]   a_tbl [4];
`ifdef WB_ARB_RR_EN
        g_tbl = '{3'b001, 3'b010, 3'b100, 3'b001};
        a_tbl = '{5'd1, 5'd2, 5'd3, 5'd1};
`else
        g_tbl = '{3'b001, 3'b001, 3'b001, 3'b001};
        a_tbl = '{5'd1, 5'd1, 5'd1, 5'd1};
`endif
        do_reset();
        bus.req_valid = 3'b111; bus.req_addr = {5'd3, 5'd2, 5'd1};
        bus.req_data = {$urandom, $urandom, $urandom};
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++; if (bus.req_ready !== g_tbl[c]) begin n_fail++; $display("FAIL arb_grant[%0d]: got %b expected %b", c, bus.req_ready, g_tbl[c]); end
            cycle();
            n_tests++; if (bus.we !== 1'b1 || bus.waddr !== a_tbl[c]) begin n_fail++; $display("FAIL arb_waddr[%0d]: got we=%b waddr=%0d expected 1/%0d", c, bus.we, bus.waddr, a_tbl[c]); end
        end
        idle_inputs();
        cycle();
    endtask

    task automatic test_r0();
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd4;
        cycle();
        bus.issue_valid = 1'b0;
        bus.req_valid = 3'b010; bus.req_addr = {5'd0, 5'd0, 5'd0}; bus.req_data = {32'd0, 32'hFFFF_FFFF, 32'd0};
        bus.raddr1 = 5'd0;
        #1;
        n_tests++; if (bus.req_ready !== 3'b010) begin n_fail++; $display("FAIL r0_grant: got %b expected 010", bus.req_ready); end
        cycle();
        bus.req_valid = 3'b000;
        #1;
        n_tests++; if (bus.we !== 1'b0 || bus.waddr !== 5'd0) begin n_fail++; $display("FAIL r0_no_write: got we=%b waddr=%0d expected 0/0", bus.we, bus.waddr); end
        n_tests++; if (bus.issue_ready !== 1'b0 || bus.rbusy1 !== 1'b0) begin n_fail++; $display("FAIL r0_busy_unchanged: got issue_ready=%b rbusy1=%b expected 0/0", bus.issue_ready, bus.rbusy1); end
        idle_inputs();
    endtask

    task automatic test_set_wins();
        do_reset();
        bus.req_valid = 3'b001; bus.req_addr = {5'd0, 5'd0, 5'd7}; bus.req_data = {32'd0, 32'd0, $urandom};
        cycle();
        bus.req_valid = 3'b000; bus.issue_valid = 1'b1; bus.issue_addr = 5'd7;
        #1;
        n_tests++; if (bus.we !== 1'b1 || bus.waddr !== 5'd7 || bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL setwins_setup: got we=%b waddr=%0d issue_ready=%b expected 1/7/1", bus.we, bus.waddr, bus.issue_ready); end
        cycle();
        bus.issue_valid = 1'b0; bus.raddr1 = 5'd7;
        #1;
        n_tests++; if (bus.issue_ready !== 1'b0 || bus.rbusy1 !== 1'b1) begin n_fail++; $display("FAIL set_wins: got issue_ready=%b rbusy1=%b expected 0/1", bus.issue_ready, bus.rbusy1); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
        cycle();
        bus.issue_valid = 1'b0;
        bus.req_valid = 3'b001; bus.req_addr = {5'd0, 5'd0, 5'd9}; bus.req_data = {32'd0, 32'd0, 32'hCAFE_F00D};
        cycle();
        bus.req_valid = 3'b000; rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.raddr1 = 5'd9; bus.raddr2 = 5'd9; bus.raddr3 = 5'd9; bus.issue_addr = 5'd9;
        #1;
        n_tests++; if (bus.we !== 1'b0 || bus.waddr !== 5'd0 || bus.wdata !== 32'd0) begin n_fail++; $display("FAIL midrst_port: got we=%b waddr=%0d wdata=%0h expected 0/0/0", bus.we, bus.waddr, bus.wdata); end
        n_tests++; if ({bus.rbusy1, bus.rbusy2, bus.rbusy3} !== 3'b000 || bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_busy: got rbusy=%b issue_ready=%b expected 000/1", {bus.rbusy1, bus.rbusy2, bus.rbusy3}, bus.issue_ready); end
        idle_inputs();
    endtask

    task automatic test_idle_then_mdu();
        logic [NREQ-1:0] exp_all;
`ifdef WB_ARB_RR_EN
        exp_all = 3'b010;
`else
        exp_all = 3'b001;
`endif
        do_reset();
        bus.req_valid = 3'b001; bus.req_addr = {5'd0, 5'd0, 5'd1};
        cycle();
        bus.req_valid = 3'b000;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++; if (bus.req_ready !== 3'b000) begin n_fail++; $display("FAIL idle_ready[%0d]: got %b expected 000", c, bus.req_ready); end
            cycle();
            n_tests++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL idle_we[%0d]: got %b expected 0", c, bus.we); end
        end
        bus.req_valid = 3'b111; bus.req_addr = {5'd3, 5'd2, 5'd1};
        #1;
        n_tests++; if (bus.req_ready !== exp_all) begin n_fail++; $display("FAIL idle_ptr_held: got %b expected %b", bus.req_ready, exp_all); end
        bus.req_valid = 3'b100; bus.req_data = {32'h0BAD_BEEF, 32'd0, 32'd0};
        #1;
        n_tests++; if (bus.req_ready !== 3'b100) begin n_fail++; $display("FAIL mdu_grant: got %b expected 100", bus.req_ready); end
        cycle();
        bus.req_valid = 3'b000;
        n_tests++; if (bus.we !== 1'b1 || bus.waddr !== 5'd3 || bus.wdata !== 32'h0BAD_BEEF) begin n_fail++; $display("FAIL mdu_write: got we=%b waddr=%0d wdata=%0h expected 1/3/badbeef", bus.we, bus.waddr, bus.wdata); end
        idle_inputs();
        cycle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin
                bus.req_addr[i*AW +: AW] = AW'($urandom_range(0, 11));
                bus.req_data[i*DW +: DW] = $urandom;
            end
            bus.issue_valid = ($urandom_range(0, 2) != 0);
            bus.issue_addr  = AW'($urandom_range(0, 11));
            bus.raddr1      = AW'($urandom_range(0, 11));
            bus.raddr2      = AW'($urandom_range(0, 11));
            bus.raddr3      = AW'($urandom_range(0, 11));
            #1;
            n_tests++; if (bus.req_ready !== exp_ready(bus.req_valid)) begin n_fail++; $display("FAIL rnd_grant[%0d]: got %b expected %b", n, bus.req_ready, exp_ready(bus.req_valid)); end
            n_tests++; if (bus.issue_ready !== exp_issue_ready(bus.issue_addr)) begin n_fail++; $display("FAIL rnd_issue_ready[%0d]: got %b expected %b", n, bus.issue_ready, exp_issue_ready(bus.issue_addr)); end
            n_tests++; if ({bus.rbusy1, bus.rbusy2, bus.rbusy3} !== {exp_rbusy(bus.raddr1), exp_rbusy(bus.raddr2), exp_rbusy(bus.raddr3)}) begin
                n_fail++; $display("FAIL rnd_rbusy[%0d]: got %b expected %b", n, {bus.rbusy1, bus.rbusy2, bus.rbusy3}, {exp_rbusy(bus.raddr1), exp_rbusy(bus.raddr2), exp_rbusy(bus.raddr3)});
            end
            cycle();
            n_tests++; if (bus.we !== m_we || bus.waddr !== m_waddr || bus.wdata !== m_wdata) begin
                n_fail++; $display("FAIL rnd_wport[%0d]: got %b/%0d/%0h expected %b/%0d/%0h", n, bus.we, bus.waddr, bus.wdata, m_we, m_waddr, m_wdata);
            end
        end
        rst = 1'b0;
        idle_inputs();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        test_reset();
        test_raw_waw();
        test_arbitration();
        test_r0();
        test_set_wins();
        test_reset_mid();
        test_idle_then_mdu();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
